// File: rtl/mem_stage_ctrl_if.sv
// Bus bundle between the EX/MEM register, the memory-stage controller,
// the data memory and the MEM/WB register.
// master: controller view (drives stall, dmem request and writeback).
// slave:  environment view (pipeline, data memory and MEM/WB register).
interface mem_stage_ctrl_if #(
  parameter int BIT_WIDTH = 32
);
  logic                 regWrEnIn;
  logic                 memWrEnIn;
  logic                 isLoadIn;
  logic                 isStoreIn;
  logic [1:0]           mulSelIn;
  logic [3:0]           regWrAddrIn;
  logic [BIT_WIDTH-1:0] aluOutIn;
  logic [BIT_WIDTH-1:0] PCIn;
  logic [BIT_WIDTH-1:0] storeDataIn;
  logic                 stall;
  logic                 dmemReq;
  logic                 dmemWe;
  logic [BIT_WIDTH-1:0] dmemAddr;
  logic [BIT_WIDTH-1:0] dmemWrData;
  logic                 dmemAck;
  logic [BIT_WIDTH-1:0] dmemRdData;
  logic                 wbValid;
  logic                 wbRegWrEn;
  logic [3:0]           wbRegWrAddr;
  logic [BIT_WIDTH-1:0] wbData;
  logic                 memErr;

  modport master (
    input  regWrEnIn, memWrEnIn, isLoadIn, isStoreIn, mulSelIn, regWrAddrIn,
    input  aluOutIn, PCIn, storeDataIn, dmemAck, dmemRdData,
    output stall, dmemReq, dmemWe, dmemAddr, dmemWrData,
    output wbValid, wbRegWrEn, wbRegWrAddr, wbData, memErr
  );

  modport slave (
    output regWrEnIn, memWrEnIn, isLoadIn, isStoreIn, mulSelIn, regWrAddrIn,
    output aluOutIn, PCIn, storeDataIn, dmemAck, dmemRdData,
    input  stall, dmemReq, dmemWe, dmemAddr, dmemWrData,
    input  wbValid, wbRegWrEn, wbRegWrAddr, wbData, memErr
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: req/ack handshake with data memory, upstream
// stall while an access is outstanding, registered writeback outputs.
// Optional build macro MEM_TIMEOUT_EN adds a WAIT-cycle abort counter
// that raises a one-cycle memErr pulse.
//
// state  | meaning
// S_IDLE | no access outstanding; memory op here issues the request
// S_WAIT | request registered, waiting for the dmemAck pulse
module mem_stage_ctrl #(
  parameter int BIT_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                reset,
  mem_stage_ctrl_if.master    bus
);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t               state_q, state_d;
  logic                 mem_op;
  logic                 store_we;
  logic                 timeout_hit;
  logic                 stall_c;
  logic [BIT_WIDTH-1:0] wb_sel_data;

  logic                 dmem_req_q, dmem_req_d;
  logic                 dmem_we_q, dmem_we_d;
  logic [BIT_WIDTH-1:0] dmem_addr_q, dmem_addr_d;
  logic [BIT_WIDTH-1:0] dmem_wr_data_q, dmem_wr_data_d;
  logic                 wb_valid_q, wb_valid_d;
  logic                 wb_reg_wr_en_q, wb_reg_wr_en_d;
  logic [3:0]           wb_reg_wr_addr_q, wb_reg_wr_addr_d;
  logic [BIT_WIDTH-1:0] wb_data_q, wb_data_d;
  logic                 mem_err_q, mem_err_d;

  assign mem_op   = bus.isLoadIn | bus.isStoreIn;
  assign store_we = bus.isStoreIn & bus.memWrEnIn;

`ifdef MEM_TIMEOUT_EN
  localparam int                 CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;

  // WAIT-cycle counter: zero in IDLE so it starts from zero on entering WAIT
  always_comb begin
    wait_cnt_d = '0;
    if (state_q == S_WAIT) wait_cnt_d = wait_cnt_q + CNT_W'(1);
  end

  // wait counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) wait_cnt_q <= '0;
    else        wait_cnt_q <= wait_cnt_d;
  end

  // an ack in the last allowed cycle wins over the abort
  assign timeout_hit = (state_q == S_WAIT) & ~bus.dmemAck & (wait_cnt_q == CNT_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (mem_op) state_d = S_WAIT;
      S_WAIT:  if (bus.dmemAck || timeout_hit) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // writeback value select
  always_comb begin
    case (bus.mulSelIn)
      2'd1:    wb_sel_data = bus.dmemRdData;
      2'd2:    wb_sel_data = bus.PCIn;
      default: wb_sel_data = bus.aluOutIn;
    endcase
  end

  // outputs: stall plus next values of the registered dmem/writeback outputs
  always_comb begin
    stall_c          = 1'b0;
    dmem_req_d       = dmem_req_q;
    dmem_we_d        = dmem_we_q;
    dmem_addr_d      = dmem_addr_q;
    dmem_wr_data_d   = dmem_wr_data_q;
    wb_valid_d       = 1'b1;
    wb_reg_wr_en_d   = bus.regWrEnIn & ~bus.isStoreIn;
    wb_reg_wr_addr_d = bus.regWrAddrIn;
    wb_data_d        = wb_sel_data;
    mem_err_d        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (mem_op) begin
          stall_c        = 1'b1;
          dmem_req_d     = 1'b1;
          dmem_we_d      = store_we;
          dmem_addr_d    = bus.aluOutIn;
          dmem_wr_data_d = bus.storeDataIn;
          wb_valid_d     = 1'b0;
          wb_reg_wr_en_d = 1'b0;
        end
      end
      S_WAIT: begin
        if (bus.dmemAck) begin
          dmem_req_d = 1'b0;
          dmem_we_d  = 1'b0;
        end else if (timeout_hit) begin
          dmem_req_d     = 1'b0;
          dmem_we_d      = 1'b0;
          wb_reg_wr_en_d = 1'b0;
          mem_err_d      = 1'b1;
        end else begin
          stall_c        = 1'b1;
          wb_valid_d     = 1'b0;
          wb_reg_wr_en_d = 1'b0;
        end
      end
      default: ;
    endcase
    // upstream must not see a stall while the controller is held in reset
    if (!reset) stall_c = 1'b0;
  end

  // registered dmem and writeback outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dmem_req_q       <= 1'b0;
      dmem_we_q        <= 1'b0;
      dmem_addr_q      <= '0;
      dmem_wr_data_q   <= '0;
      wb_valid_q       <= 1'b0;
      wb_reg_wr_en_q   <= 1'b0;
      wb_reg_wr_addr_q <= '0;
      wb_data_q        <= '0;
      mem_err_q        <= 1'b0;
    end else begin
      dmem_req_q       <= dmem_req_d;
      dmem_we_q        <= dmem_we_d;
      dmem_addr_q      <= dmem_addr_d;
      dmem_wr_data_q   <= dmem_wr_data_d;
      wb_valid_q       <= wb_valid_d;
      wb_reg_wr_en_q   <= wb_reg_wr_en_d;
      wb_reg_wr_addr_q <= wb_reg_wr_addr_d;
      wb_data_q        <= wb_data_d;
      mem_err_q        <= mem_err_d;
    end
  end

  assign bus.stall       = stall_c;
  assign bus.dmemReq     = dmem_req_q;
  assign bus.dmemWe      = dmem_we_q;
  assign bus.dmemAddr    = dmem_addr_q;
  assign bus.dmemWrData  = dmem_wr_data_q;
  assign bus.wbValid     = wb_valid_q;
  assign bus.wbRegWrEn   = wb_reg_wr_en_q;
  assign bus.wbRegWrAddr = wb_reg_wr_addr_q;
  assign bus.wbData      = wb_data_q;
  assign bus.memErr      = mem_err_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Bench for mem_stage_ctrl: directed vector table, random instruction stream
// against a transaction-level expectation model, reset and timeout sequences.
module tb_mem_stage_ctrl;
  localparam int BW = 32;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  mem_stage_ctrl_if #(.BIT_WIDTH(BW)) bus ();

  mem_stage_ctrl #(.BIT_WIDTH(BW), .TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_load, is_store, mem_wr_en, reg_wr_en;
    logic [1:0]  mul_sel;
    logic [3:0]  rd_addr;
    logic [31:0] alu, pc, sdata, rdata;
    int          ack_at;
    logic        exp_wren, exp_we;
    logic [31:0] exp_data;
    int          exp_stall;
  } vec_t;

  function automatic vec_t mk(input logic ld, input logic st, input logic mwe, input logic rwe,
                              input logic [1:0] sel, input logic [3:0] ra,
                              input logic [31:0] alu, input logic [31:0] pc,
                              input logic [31:0] sd, input logic [31:0] rd, input int ack_at,
                              input logic e_wren, input logic e_we, input logic [31:0] e_data,
                              input int e_stall);
    vec_t v;
    v.is_load = ld; v.is_store = st; v.mem_wr_en = mwe; v.reg_wr_en = rwe;
    v.mul_sel = sel; v.rd_addr = ra; v.alu = alu; v.pc = pc; v.sdata = sd; v.rdata = rd;
    v.ack_at = ack_at; v.exp_wren = e_wren; v.exp_we = e_we; v.exp_data = e_data;
    v.exp_stall = e_stall;
    return v;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.isLoadIn    = v.is_load;
    bus.isStoreIn   = v.is_store;
    bus.memWrEnIn   = v.mem_wr_en;
    bus.regWrEnIn   = v.reg_wr_en;
    bus.mulSelIn    = v.mul_sel;
    bus.regWrAddrIn = v.rd_addr;
    bus.aluOutIn    = v.alu;
    bus.PCIn        = v.pc;
    bus.storeDataIn = v.sdata;
  endtask

  task automatic drive_nop();
    vec_t v;
    v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(v);
    bus.dmemAck    = 1'b0;
    bus.dmemRdData = '0;
  endtask

  // Present one instruction; ack (or an ignored IDLE ack for non-memory ops)
  // lands in cycle ack_at. Runs until wbValid or a cycle budget expires.
  task automatic apply(input vec_t v, input string nm);
    int stalls;
    int cyc;
    bit done;
    stalls = 0; cyc = 0; done = 0;
    drive(v);
    while (!done && cyc < 20) begin
      bus.dmemAck    = (cyc == v.ack_at);
      bus.dmemRdData = (cyc == v.ack_at) ? v.rdata : $urandom;
      #1;
      if (bus.stall) stalls++;
      @(posedge clk); #1;
      cyc++;
      bus.dmemAck = 1'b0;
      if (bus.wbValid) done = 1;
      else begin
        check({nm, "_wait_req"},    bus.dmemReq,    1);
        check({nm, "_wait_addr"},   bus.dmemAddr,   v.alu);
        check({nm, "_wait_we"},     bus.dmemWe,     v.exp_we);
        check({nm, "_wait_wdata"},  bus.dmemWrData, v.sdata);
        check({nm, "_bubble_wren"}, bus.wbRegWrEn,  0);
      end
    end
    check({nm, "_completed"}, done,          1);
    check({nm, "_stall_cyc"}, stalls,        v.exp_stall);
    check({nm, "_latency"},   cyc,           v.exp_stall + 1);
    check({nm, "_wren"},      bus.wbRegWrEn, v.exp_wren);
    check({nm, "_waddr"},     bus.wbRegWrAddr, v.rd_addr);
    check({nm, "_wdata"},     bus.wbData,    v.exp_data);
    check({nm, "_req_low"},   bus.dmemReq,   0);
    check({nm, "_memerr"},    bus.memErr,    0);
  endtask

  vec_t tbl[9];

  initial begin
    vec_t v;
    int   stalls;
    int   cyc;
    bit   done;

    tbl[0] = mk(0,0,0,1,0, 5, 32'h1234, 32'h100,  0,        32'h9999, 0, 1,0,32'h1234, 0);
    tbl[1] = mk(1,0,0,1,1, 7, 32'h40,   32'h104,  0,        32'hCAFE, 4, 1,0,32'hCAFE, 4);
    tbl[2] = mk(0,1,1,1,0, 2, 32'h80,   32'h108,  32'hDEAD, 32'h5555, 1, 0,1,32'h80,   1);
    tbl[3] = mk(0,0,0,1,2, 3, 32'h55,   32'h2000, 0,        32'h1,    0, 1,0,32'h2000, 0);
    tbl[4] = mk(0,0,0,0,3, 4, 32'h77,   32'h2004, 0,        32'h2,    0, 0,0,32'h77,   0);
    tbl[5] = mk(1,1,1,1,1, 6, 32'h90,   32'h2008, 32'h1357, 32'hBEEF, 2, 0,1,32'hBEEF, 2);
    tbl[6] = mk(1,0,0,1,0, 8, 32'h44,   32'h200C, 0,        32'h3,    1, 1,0,32'h44,   1);
    tbl[7] = mk(1,1,0,1,2, 9, 32'hA0,   32'h300,  32'h2468, 32'h4,    3, 0,0,32'h300,  3);
    tbl[8] = mk(0,0,0,1,1,10, 32'h11,   32'h304,  0,        32'hF00D, 0, 1,0,32'hF00D, 0);

    // reset state, with a memory op presented to prove stall is held low
    reset = 1'b0;
    drive_nop();
    bus.isLoadIn = 1'b1;
    #3;
    check("rst_stall",    bus.stall,       0);
    check("rst_req",      bus.dmemReq,     0);
    check("rst_we",       bus.dmemWe,      0);
    check("rst_addr",     bus.dmemAddr,    0);
    check("rst_wbvalid",  bus.wbValid,     0);
    check("rst_wbdata",   bus.wbData,      0);
    check("rst_memerr",   bus.memErr,      0);
    bus.isLoadIn = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // directed table
    for (int i = 0; i < 9; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // random stream against the transaction-level model
    for (int i = 0; i < 60; i++) begin
      int kind;
      kind = $urandom_range(0, 3);
      v.is_load   = (kind == 2) || (kind == 3 && $urandom_range(0, 3) == 0);
      v.is_store  = (kind == 3);
      v.mem_wr_en = $urandom_range(0, 1);
      v.reg_wr_en = $urandom_range(0, 1);
      v.mul_sel   = 2'($urandom_range(0, 3));
      v.rd_addr   = 4'($urandom_range(0, 15));
      v.alu       = $urandom;
      v.pc        = $urandom;
      v.sdata     = $urandom;
      v.rdata     = $urandom;
      v.ack_at    = (v.is_load || v.is_store) ? $urandom_range(1, TO) : 0;
      v.exp_we    = v.is_store & v.mem_wr_en;
      v.exp_wren  = v.reg_wr_en & ~v.is_store;
      v.exp_stall = v.ack_at;
      case (v.mul_sel)
        2'd1:    v.exp_data = v.rdata;
        2'd2:    v.exp_data = v.pc;
        default: v.exp_data = v.alu;
      endcase
      apply(v, $sformatf("rnd%0d", i));
    end

    // reset asserted mid-WAIT, late ack ignored, clean restart afterwards
    v = mk(1,0,0,1,1, 9, 32'h60, 32'h500, 0, 0, 0, 0,0,0, 0);
    drive(v);
    bus.dmemAck = 1'b0;
    #1;
    check("rstw_stall_idle", bus.stall, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rstw_req_wait", bus.dmemReq, 1);
    #2 reset = 1'b0;
    #1;
    check("rstw_req_async",   bus.dmemReq, 0);
    check("rstw_stall_async", bus.stall,   0);
    @(posedge clk); #1;
    bus.dmemAck = 1'b1;
    @(posedge clk); #1;
    bus.dmemAck = 1'b0;
    check("rstw_late_ack_wb", bus.wbValid, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rstw_rel_req",    bus.dmemReq,     0);
    check("rstw_rel_we",     bus.dmemWe,      0);
    check("rstw_rel_addr",   bus.dmemAddr,    0);
    check("rstw_rel_wdata",  bus.dmemWrData,  0);
    check("rstw_rel_valid",  bus.wbValid,     0);
    check("rstw_rel_wren",   bus.wbRegWrEn,   0);
    check("rstw_rel_waddr",  bus.wbRegWrAddr, 0);
    check("rstw_rel_wbdata", bus.wbData,      0);
    check("rstw_rel_memerr", bus.memErr,      0);
    check("rstw_rel_stall",  bus.stall,       1);
    bus.dmemAck    = 1'b1;
    bus.dmemRdData = 32'h2222;
    @(posedge clk); #1;
    bus.dmemAck = 1'b0;
    check("rstw_idle_ack_wb",  bus.wbValid,  0);
    check("rstw_idle_ack_req", bus.dmemReq,  1);
    check("rstw_idle_ack_adr", bus.dmemAddr, 32'h60);
    bus.dmemAck    = 1'b1;
    bus.dmemRdData = 32'h1111;
    #1;
    check("rstw_ack_stall", bus.stall, 0);
    @(posedge clk); #1;
    bus.dmemAck = 1'b0;
    check("rstw_done_valid", bus.wbValid,     1);
    check("rstw_done_data",  bus.wbData,      32'h1111);
    check("rstw_done_wren",  bus.wbRegWrEn,   1);
    check("rstw_done_waddr", bus.wbRegWrAddr, 9);
    check("rstw_done_req",   bus.dmemReq,     0);

`ifdef MEM_TIMEOUT_EN
    // load that is never acknowledged must abort after TO WAIT cycles
    v = mk(1,0,0,1,0, 12, 32'h700, 32'h600, 0, 0, 0, 0,0,0, 0);
    drive(v);
    bus.dmemAck = 1'b0;
    stalls = 0; cyc = 0; done = 0;
    while (!done && cyc < 20) begin
      #1;
      if (bus.stall) stalls++;
      @(posedge clk); #1;
      cyc++;
      if (bus.wbValid) done = 1;
      else check("to_no_early_err", bus.memErr, 0);
    end
    check("to_completed", done,          1);
    check("to_stall_cyc", stalls,        TO);
    check("to_latency",   cyc,           TO + 1);
    check("to_memerr",    bus.memErr,    1);
    check("to_wren",      bus.wbRegWrEn, 0);
    check("to_req_low",   bus.dmemReq,   0);
    apply(tbl[0], "to_next");
`endif

    drive_nop();
    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
